memchr: RTL and testbench

MEMCHR -- requirements
Module: memchr

---
 rtl/memchr.sv | 161 ++++++++++++++++
 tb/tb_memchr.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/memchr.sv
// rtl/memchr.sv - word-by-word memory search for the first word whose low bits match a pattern
//
// Optional feature: define MEMCHR_ABORT_EN to add the abort input.
//
// Ports:
//   clk, reset_n                    clock, synchronous active-low reset
//   start, m, c, n                  search request: base address, pattern, word count
//   abort                           (MEMCHR_ABORT_EN only) cancel a search in progress
//   finish                          one-cycle completion pulse
//   found, return_val               result: match flag and address of first match
//   memory_controller_address       read address, held through the data-return cycle
//   memory_controller_write_enable  tied 0 (read-only engine)
//   memory_controller_in            tied 0
//   memory_controller_out           read data, valid one cycle after the address
module memchr #(
  parameter int ADDR_WIDTH  = 32,
  parameter int MATCH_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] m,
  input  logic [31:0]           c,
  input  logic [ADDR_WIDTH-1:0] n,
`ifdef MEMCHR_ABORT_EN
  input  logic                  abort,
`endif
  output logic                  finish,
  output logic                  found,
  output logic [ADDR_WIDTH-1:0] return_val,
  output logic [ADDR_WIDTH-1:0] memory_controller_address,
  output logic                  memory_controller_write_enable,
  output logic [31:0]           memory_controller_in,
  input  logic [31:0]           memory_controller_out
);

  typedef enum logic [1:0] {IDLE, ISSUE, CHECK, DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

  state_t                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  base_q, base_d;
  logic [MATCH_WIDTH-1:0] pat_q, pat_d;
  logic [ADDR_WIDTH-1:0]  cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]  idx_q, idx_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic                   finish_q, finish_d;
  logic                   found_q, found_d;
  logic [ADDR_WIDTH-1:0]  ret_q, ret_d;

  logic hit;
  logic last;
  logic abort_hit;
  logic unused_bits;

  assign hit  = (memory_controller_out[MATCH_WIDTH-1:0] == pat_q);
  assign last = ((idx_q + ADDR_ONE) == cnt_q);

`ifdef MEMCHR_ABORT_EN
  assign abort_hit = abort;
`else
  assign abort_hit = 1'b0;
`endif

  // Only the low MATCH_WIDTH bits of c and of the read data take part in the compare.
  assign unused_bits = ^{c, memory_controller_out};

  // State register and datapath flops.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      base_q   <= '0;
      pat_q    <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      addr_q   <= '0;
      finish_q <= 1'b0;
      found_q  <= 1'b0;
      ret_q    <= '0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      pat_q    <= pat_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      addr_q   <= addr_d;
      finish_q <= finish_d;
      found_q  <= found_d;
      ret_q    <= ret_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start) state_d = (n == '0) ? DONE : ISSUE;
      ISSUE: state_d = abort_hit ? DONE : CHECK;
      CHECK: state_d = (abort_hit || hit || last) ? DONE : ISSUE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath logic. The address register is loaded on entry to ISSUE
  // so it presents base+idx during ISSUE and holds it while data returns in CHECK.
  always_comb begin
    base_d  = base_q;
    pat_d   = pat_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    found_d = found_q;
    ret_d   = ret_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          base_d  = m;
          pat_d   = c[MATCH_WIDTH-1:0];
          cnt_d   = n;
          idx_d   = '0;
          found_d = 1'b0;
          ret_d   = '0;
          if (n != '0) addr_d = m;
        end
      end
      ISSUE: begin
        if (abort_hit) begin
          found_d = 1'b0;
          ret_d   = '0;
        end
      end
      CHECK: begin
        // Abort outranks a match seen in the same cycle.
        if (abort_hit) begin
          found_d = 1'b0;
          ret_d   = '0;
        end else if (hit) begin
          found_d = 1'b1;
          ret_d   = base_q + idx_q;
        end else if (last) begin
          found_d = 1'b0;
          ret_d   = '0;
        end else begin
          idx_d  = idx_q + ADDR_ONE;
          addr_d = base_q + idx_q + ADDR_ONE;
        end
      end
      default: ;
    endcase
    finish_d = (state_d == DONE);
  end

  assign finish                         = finish_q;
  assign found                          = found_q;
  assign return_val                     = ret_q;
  assign memory_controller_address      = addr_q;
  assign memory_controller_write_enable = 1'b0;
  assign memory_controller_in           = '0;

endmodule

// File: tb/tb_memchr.sv
// tb/tb_memchr.sv - scoreboard bench for memchr
module tb_memchr;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [31:0] m, c, n;
  logic        abort;
  logic        finish, found;
  logic [31:0] return_val, mc_addr, mc_in, mc_out;
  logic        mc_we;

  always #5 clk = ~clk;

  memchr dut (
    .clk                            (clk),
    .reset_n                        (reset_n),
    .start                          (start),
    .m                              (m),
    .c                              (c),
    .n                              (n),
`ifdef MEMCHR_ABORT_EN
    .abort                          (abort),
`endif
    .finish                         (finish),
    .found                          (found),
    .return_val                     (return_val),
    .memory_controller_address      (mc_addr),
    .memory_controller_write_enable (mc_we),
    .memory_controller_in           (mc_in),
    .memory_controller_out          (mc_out)
  );

  logic [31:0] mem [0:255];
  always @(posedge clk) mc_out <= mem[mc_addr[7:0]];

  typedef struct {
    logic        found;
    logic [31:0] ret;
    int          cyc;
  } exp_t;

  exp_t expq[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic side_bad = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every finish pulse is matched against the oldest expected result.
  always @(negedge clk) begin
    if (mc_we !== 1'b0 || mc_in !== 32'h0) side_bad = 1'b1;
    if (reset_n && finish === 1'b1) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_finish: got finish=1 at cycle %0d expected no pulse", cyc);
      end else begin
        exp_t e;
        e = expq.pop_front();
        chk("found", {31'b0, found}, {31'b0, e.found});
        chk("return_val", return_val, e.ret);
        chk("finish_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic wait_drain(input string name);
    for (int k = 0; k < 60 && expq.size() != 0; k++) @(negedge clk);
    @(negedge clk);
    if (expq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout_%s: got %0d pending results expected 0", name, expq.size());
      expq.delete();
    end
  endtask

  // Issue one search; lat is the finish latency counted from the start-sampling edge.
  task automatic search(input string name, input logic [31:0] mm, input logic [31:0] nn,
                        input logic [31:0] cc, input logic ef, input logic [31:0] er, input int lat);
    exp_t e;
    @(negedge clk);
    m = mm; n = nn; c = cc; start = 1'b1;
    @(posedge clk);
    #1;
    e.found = ef; e.ret = er; e.cyc = cyc + lat - 1;
    expq.push_back(e);
    start = 1'b0;
    wait_drain(name);
  endtask

  initial begin
    exp_t e;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h10] = 32'h41;
    mem[8'h11] = 32'hDEAD0042;
    mem[8'h12] = 32'h43;
    mem[8'h13] = 32'h44;
    mem[8'h00] = 32'h77;
    mem[8'hFF] = 32'h00;
    reset_n = 1'b0; start = 1'b0; abort = 1'b0;
    m = 32'h0; n = 32'h0; c = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_finish", {31'b0, finish}, 32'h0);
    chk("rst_found", {31'b0, found}, 32'h0);
    chk("rst_return_val", return_val, 32'h0);
    chk("rst_address", mc_addr, 32'h0);
    reset_n = 1'b1;

    search("match_idx2", 32'h10, 32'd4, 32'h43, 1'b1, 32'h12, 7);

    // n==0 with start held through DONE: one pulse only, address untouched.
    @(negedge clk);
    m = 32'h40; n = 32'd0; c = 32'h43; start = 1'b1;
    @(posedge clk);
    #1;
    e.found = 1'b0; e.ret = 32'h0; e.cyc = cyc;
    expq.push_back(e);
    @(negedge clk);
    chk("n0_address_held", mc_addr, 32'h12);
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_drain("n0");
    repeat (3) @(negedge clk);

    search("no_match", 32'h10, 32'd4, 32'h55, 1'b0, 32'h0, 9);
    search("match_idx0", 32'h10, 32'd4, 32'h41, 1'b1, 32'h10, 3);
    search("match_last", 32'h10, 32'd4, 32'h44, 1'b1, 32'h13, 9);
    search("low_bits_only", 32'h10, 32'd4, 32'hFFFFFF42, 1'b1, 32'h11, 5);
    search("wrap", 32'hFFFFFFFF, 32'd2, 32'h77, 1'b1, 32'h0, 5);
    search("n1_miss", 32'h20, 32'd1, 32'h99, 1'b0, 32'h0, 3);
    search("match_idx2_again", 32'h10, 32'd4, 32'h43, 1'b1, 32'h12, 7);

    // Reset during CHECK of word 2 (state after the 6th edge from start).
    @(negedge clk);
    m = 32'h10; n = 32'd4; c = 32'h55; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_address", mc_addr, 32'h12);
    reset_n = 1'b0;
    @(negedge clk);
    chk("midrst_finish", {31'b0, finish}, 32'h0);
    chk("midrst_found", {31'b0, found}, 32'h0);
    chk("midrst_return_val", return_val, 32'h0);
    chk("midrst_address", mc_addr, 32'h0);
    reset_n = 1'b1;
    repeat (12) @(negedge clk);

    search("after_reset", 32'h10, 32'd4, 32'h43, 1'b1, 32'h12, 7);

`ifdef MEMCHR_ABORT_EN
    // Abort coincides with the CHECK cycle that would match word 0.
    @(negedge clk);
    m = 32'h10; n = 32'd4; c = 32'h41; start = 1'b1;
    @(posedge clk);
    #1;
    e.found = 1'b0; e.ret = 32'h0; e.cyc = cyc + 2;
    expq.push_back(e);
    start = 1'b0;
    @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    wait_drain("abort");
`endif

    chk("write_side_idle", {31'b0, side_bad}, 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
